lfsr_countdown_timer: RTL and testbench

Parametrised game countdown timer built on an LFSR prescaler. A Galois LFSR divides Clock down to a base tick, typically 1 ms. A loadable down-counter counts those ticks and flags expiry. It adds start, pause, abort, auto-reload and a remaining-count readout, and serves as the round/answer timer for the game controller.

---
 rtl/timer_pkg.sv | 17 +
 rtl/lfsr_prescaler.sv | 37 +++
 rtl/lfsr_countdown_timer.sv | 112 +++++++++++
 tb/tb_lfsr_countdown_timer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the LFSR countdown timer: FSM encoding and the
// default 16-bit prescaler constants for a 1 ms base tick.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam int          DEFAULT_LFSR_WIDTH  = 16;
    localparam logic [15:0] DEFAULT_TAPS        = 16'h002C;
    localparam logic [15:0] DEFAULT_SEED        = 16'hFFFF;
    localparam logic [15:0] DEFAULT_TERMINAL    = 16'h6DB6;
    localparam int          DEFAULT_COUNT_WIDTH = 10;

endpackage

// File: rtl/lfsr_prescaler.sv
// Galois LFSR prescaler: steps while Advance is high and reloads SEED after
// reaching TERMINAL, flagging that wrap combinationally.
module lfsr_prescaler #(
    parameter int               W        = 16,
    parameter logic [W-1:0]     TAPS     = 16'h002C,
    parameter logic [W-1:0]     SEED     = 16'hFFFF,
    parameter logic [W-1:0]     TERMINAL = 16'h6DB6
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Advance,
    output logic Wrap
);

    logic [W-1:0] lfsr_reg;
    logic [W-1:0] step;

    // Shift-left Galois step; the msb feeds bit 0 and every tapped stage.
    assign step[0] = lfsr_reg[W-1];
    generate
        for (genvar gi = 1; gi < W; gi++) begin : g_stage
            assign step[gi] = lfsr_reg[gi-1] ^ (TAPS[gi] & lfsr_reg[W-1]);
        end
    endgenerate

    assign Wrap = (lfsr_reg == TERMINAL) && Advance;

    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            lfsr_reg <= SEED;
        end else if (Advance) begin
            lfsr_reg <= (lfsr_reg == TERMINAL) ? SEED : step;
        end
    end

endmodule

// File: rtl/lfsr_countdown_timer.sv
// Loadable down-counter of LFSR base ticks with start/pause/abort,
// auto-reload and a registered remaining-count readout.
module lfsr_countdown_timer
    import timer_pkg::*;
#(
    parameter int                      LFSR_WIDTH  = DEFAULT_LFSR_WIDTH,
    parameter logic [LFSR_WIDTH-1:0]   TAPS        = LFSR_WIDTH'(DEFAULT_TAPS),
    parameter logic [LFSR_WIDTH-1:0]   SEED        = LFSR_WIDTH'(DEFAULT_SEED),
    parameter logic [LFSR_WIDTH-1:0]   TERMINAL    = LFSR_WIDTH'(DEFAULT_TERMINAL),
    parameter int                      COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [COUNT_WIDTH-1:0] LoadValue,
    input  logic                   AutoReload,
    input  logic                   Pause,
    input  logic                   Abort,
    output logic                   Tick,
    output logic [COUNT_WIDTH-1:0] Remaining,
    output logic                   Busy,
    output logic                   Expired,
    output logic                   Done
);

    state_t                 state_reg, state_next;
    logic [COUNT_WIDTH-1:0] remaining_reg;
    logic [COUNT_WIDTH-1:0] reload_reg;
    logic                   mode_reg;
    logic                   tick_reg;
    logic                   expired_reg;
    logic                   advance;
    logic                   clear;
    logic                   wrap;
    logic                   last_tick;

    // Start/Abort outrank Pause, so the prescaler only runs on a quiet cycle.
    assign advance   = (state_reg == RUNNING) && !Pause && !Start && !Abort;
    assign clear     = Start || Abort;
    assign last_tick = wrap && (remaining_reg == COUNT_WIDTH'(1));

    lfsr_prescaler #(
        .W        (LFSR_WIDTH),
        .TAPS     (TAPS),
        .SEED     (SEED),
        .TERMINAL (TERMINAL)
    ) u_prescaler (
        .Clock   (Clock),
        .Reset   (Reset),
        .Clear   (clear),
        .Advance (advance),
        .Wrap    (wrap)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (Start) begin
            state_next = (LoadValue != '0) ? RUNNING : EXPIRED;
        end else if (Abort) begin
            state_next = IDLE;
        end else if (last_tick && !mode_reg) begin
            state_next = EXPIRED;
        end
    end

    always_comb begin
        Busy = (state_reg == RUNNING);
        Done = (state_reg == EXPIRED);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            remaining_reg <= '0;
            reload_reg    <= '0;
            mode_reg      <= 1'b0;
            tick_reg      <= 1'b0;
            expired_reg   <= 1'b0;
        end else begin
            tick_reg    <= 1'b0;
            expired_reg <= 1'b0;
            if (Start) begin
                remaining_reg <= LoadValue;
                reload_reg    <= LoadValue;
                mode_reg      <= AutoReload;
                expired_reg   <= (LoadValue == '0);
            end else if (Abort) begin
                remaining_reg <= '0;
            end else if (wrap) begin
                tick_reg <= 1'b1;
                if (last_tick) begin
                    expired_reg   <= 1'b1;
                    remaining_reg <= mode_reg ? reload_reg : '0;
                end else if (remaining_reg != '0) begin
                    remaining_reg <= remaining_reg - COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign Tick      = tick_reg;
    assign Expired   = expired_reg;
    assign Remaining = remaining_reg;

endmodule

// File: tb/tb_lfsr_countdown_timer.sv
// Directed bench for lfsr_countdown_timer (W=4, P=5, C=4): expected output
// snapshots are queued per cycle when stimulus is issued and checked at negedge.
module tb_lfsr_countdown_timer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [3:0] LoadValue = 4'd0;
    logic       AutoReload = 1'b0;
    logic       Pause = 1'b0;
    logic       Abort = 1'b0;
    logic       Tick;
    logic [3:0] Remaining;
    logic       Busy;
    logic       Expired;
    logic       Done;

    lfsr_countdown_timer #(
        .LFSR_WIDTH  (4),
        .TAPS        (4'b0010),
        .SEED        (4'hF),
        .TERMINAL    (4'h2),
        .COUNT_WIDTH (4)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .LoadValue  (LoadValue),
        .AutoReload (AutoReload),
        .Pause      (Pause),
        .Abort      (Abort),
        .Tick       (Tick),
        .Remaining  (Remaining),
        .Busy       (Busy),
        .Expired    (Expired),
        .Done       (Done)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic       tick;
        logic [3:0] rem;
        logic       exp;
        logic       busy;
        logic       done;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(string name, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic push(int at, logic tick, logic [3:0] rem, logic exp,
                        logic busy, logic done, string tag);
        exp_t e;
        e.at = at; e.tick = tick; e.rem = rem; e.exp = exp;
        e.busy = busy; e.done = done; e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge Clock) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) begin
                check({e.tag, "_missed"}, 32'(cyc), 32'(e.at));
            end else begin
                check({e.tag, "_tick"},    32'(Tick),      32'(e.tick));
                check({e.tag, "_rem"},     32'(Remaining), 32'(e.rem));
                check({e.tag, "_expired"}, 32'(Expired),   32'(e.exp));
                check({e.tag, "_busy"},    32'(Busy),      32'(e.busy));
                check({e.tag, "_done"},    32'(Done),      32'(e.done));
            end
        end
    end

    initial begin
        int k;
        // Reset for two edges, then a long idle stretch with nothing moving.
        push(1, 0, 0, 0, 0, 0, "rst1");
        push(2, 0, 0, 0, 0, 0, "rst2");
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        k = cyc;
        for (int i = 1; i <= 20; i++) push(k + i, 0, 0, 0, 0, 0, $sformatf("idle_i%0d", i));
        $display("step idle: 20 cycles after reset");
        repeat (20) @(negedge Clock);

        // One-shot load of 3: ticks every 5 cycles, expiry on the third.
        k = cyc + 1;
        for (int i = 0; i < 20; i++)
            push(k + i, (i == 5 || i == 10 || i == 15),
                 (i < 5) ? 4'd3 : (i < 10) ? 4'd2 : (i < 15) ? 4'd1 : 4'd0,
                 (i == 15), (i < 15), (i >= 15), $sformatf("load3_i%0d", i));
        $display("step start: load=3 auto=0 at edge %0d", k);
        LoadValue = 4'd3; Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        repeat (19) @(negedge Clock);

        // Load 2 with a 7-cycle pause beginning two edges in.
        k = cyc + 1;
        for (int i = 0; i < 22; i++)
            push(k + i, (i == 12 || i == 17),
                 (i < 12) ? 4'd2 : (i < 17) ? 4'd1 : 4'd0,
                 (i == 17), (i < 17), (i >= 17), $sformatf("pause_i%0d", i));
        $display("step start: load=2 with pause at edge %0d", k);
        LoadValue = 4'd2; Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        @(negedge Clock); Pause = 1'b1;
        repeat (7) @(negedge Clock);
        Pause = 1'b0;
        repeat (13) @(negedge Clock);

        // Zero load expires on the Start edge itself.
        k = cyc + 1;
        for (int i = 0; i < 6; i++)
            push(k + i, 0, 0, (i == 0), 0, 1, $sformatf("load0_i%0d", i));
        $display("step start: load=0 at edge %0d", k);
        LoadValue = 4'd0; Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        repeat (5) @(negedge Clock);

        // Periodic mode: reload 2 on each expiry, then abort.
        k = cyc + 1;
        for (int i = 0; i < 32; i++)
            push(k + i, (i > 0 && i % 5 == 0),
                 (i < 5) ? 4'd2 : (((i / 5) % 2) == 1) ? 4'd1 : 4'd2,
                 (i == 10 || i == 20 || i == 30), 1, 0, $sformatf("auto_i%0d", i));
        for (int i = 32; i < 37; i++) push(k + i, 0, 0, 0, 0, 0, $sformatf("abort_i%0d", i));
        $display("step start: load=2 auto=1 at edge %0d, abort at edge %0d", k, k + 32);
        LoadValue = 4'd2; AutoReload = 1'b1; Start = 1'b1;
        @(negedge Clock); Start = 1'b0; AutoReload = 1'b0;
        repeat (31) @(negedge Clock);
        Abort = 1'b1;
        @(negedge Clock); Abort = 1'b0;
        repeat (4) @(negedge Clock);

        // Reset in the middle of a run: no expiry, everything back to zero.
        k = cyc + 1;
        for (int i = 0; i < 7; i++)
            push(k + i, (i == 5), (i < 5) ? 4'd5 : 4'd4, 0, 1, 0, $sformatf("midrst_i%0d", i));
        for (int i = 7; i < 11; i++) push(k + i, 0, 0, 0, 0, 0, $sformatf("postrst_i%0d", i));
        $display("step start: load=5 at edge %0d, reset at edge %0d", k, k + 7);
        LoadValue = 4'd5; Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        repeat (6) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock); Reset = 1'b0;
        repeat (3) @(negedge Clock);

        // Start and Abort together: Start wins.
        k = cyc + 1;
        for (int i = 0; i < 7; i++)
            push(k + i, (i == 5), (i < 5) ? 4'd6 : 4'd5, 0, 1, 0, $sformatf("stab_i%0d", i));
        $display("step start+abort: load=6 at edge %0d", k);
        LoadValue = 4'd6; Start = 1'b1; Abort = 1'b1;
        @(negedge Clock); Start = 1'b0; Abort = 1'b0;
        repeat (6) @(negedge Clock);

        // Restart while running: prescaler must begin again from SEED.
        k = cyc + 1;
        for (int i = 0; i < 7; i++)
            push(k + i, (i == 5), (i < 5) ? 4'd1 : 4'd0, (i == 5), (i < 5), (i >= 5),
                 $sformatf("restart_i%0d", i));
        $display("step restart: load=1 at edge %0d", k);
        LoadValue = 4'd1; Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        repeat (6) @(negedge Clock);

        for (int n = 0; n < 50 && sb.size() > 0; n++) @(negedge Clock);
        check("drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
